// File: rtl/decode_pkg.sv
// Shared opcodes, FSM state type and IR field-offset helpers for the decode stage.
package decode_pkg;

  localparam int unsigned OPC_W = 8;

  localparam logic [OPC_W-1:0] OPC_NOP  = 8'd0;
  localparam logic [OPC_W-1:0] OPC_LW   = 8'd1;
  localparam logic [OPC_W-1:0] OPC_SW   = 8'd2;
  localparam logic [OPC_W-1:0] OPC_ADD  = 8'd3;
  localparam logic [OPC_W-1:0] OPC_SUB  = 8'd4;
  localparam logic [OPC_W-1:0] OPC_ADDI = 8'd5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_STALL = 2'd2
  } stage_state_e;

  // Total instruction width for selector width r and immediate width i.
  function automatic int unsigned ir_width(input int unsigned r, input int unsigned i);
    return OPC_W + 2 * r + i;
  endfunction

  // LSB of the write selector in LW/ADDI/ADD/SUB (directly below the opcode).
  function automatic int unsigned ws_lsb(input int unsigned r, input int unsigned i);
    return r + i;
  endfunction

  // LSB of the immediate in LW/ADDI (above rs1).
  function automatic int unsigned imm_i_lsb(input int unsigned r);
    return r;
  endfunction

  // LSB of the immediate in SW (above rs1 and rs2).
  function automatic int unsigned imm_s_lsb(input int unsigned r);
    return 2 * r;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Upstream IR handshake plus downstream decoded-field handshake of the decode stage.
interface decode_stage_if
  import decode_pkg::*;
#(
  parameter int unsigned REG_SEL_W = 4,
  parameter int unsigned IMM_W     = 16
);
  localparam int unsigned IR_W = ir_width(REG_SEL_W, IMM_W);

  logic                 i_valid;
  logic                 o_ready;
  logic [IR_W-1:0]      i_ir;
  logic                 o_valid;
  logic                 i_ready;
  logic [OPC_W-1:0]     o_opcode;
  logic                 o_re1;
  logic                 o_re2;
  logic [REG_SEL_W-1:0] o_rs1;
  logic [REG_SEL_W-1:0] o_rs2;
  logic                 o_we;
  logic [REG_SEL_W-1:0] o_ws;
  logic                 o_ie;
  logic [IMM_W-1:0]     o_id;
  logic                 o_illegal;

  modport master (
    output i_valid, i_ir, i_ready,
    input  o_ready, o_valid, o_opcode, o_re1, o_re2, o_rs1, o_rs2,
           o_we, o_ws, o_ie, o_id, o_illegal
  );

  modport slave (
    input  i_valid, i_ir, i_ready,
    output o_ready, o_valid, o_opcode, o_re1, o_re2, o_rs1, o_rs2,
           o_we, o_ws, o_ie, o_id, o_illegal
  );

endinterface

// File: rtl/decode_fields.sv
// Combinational IR -> decoded fields; unknown opcodes decode as NOP with illegal set.
module decode_fields
  import decode_pkg::*;
#(
  parameter  int unsigned REG_SEL_W = 4,
  parameter  int unsigned IMM_W     = 16,
  localparam int unsigned IR_W      = ir_width(REG_SEL_W, IMM_W)
) (
  input  logic [IR_W-1:0]      ir,
  output logic [OPC_W-1:0]     opcode,
  output logic                 re1,
  output logic                 re2,
  output logic [REG_SEL_W-1:0] rs1,
  output logic [REG_SEL_W-1:0] rs2,
  output logic                 we,
  output logic [REG_SEL_W-1:0] ws,
  output logic                 ie,
  output logic [IMM_W-1:0]     id,
  output logic                 illegal
);
  localparam int unsigned WS_LSB  = ws_lsb(REG_SEL_W, IMM_W);
  localparam int unsigned IMI_LSB = imm_i_lsb(REG_SEL_W);
  localparam int unsigned IMS_LSB = imm_s_lsb(REG_SEL_W);

  logic [OPC_W-1:0] opc_raw;

  assign opc_raw = ir[IR_W-1 -: OPC_W];

  // Field extraction per instruction format; unused fields stay zero.
  always_comb begin
    opcode  = opc_raw;
    re1     = 1'b0;
    re2     = 1'b0;
    rs1     = '0;
    rs2     = '0;
    we      = 1'b0;
    ws      = '0;
    ie      = 1'b0;
    id      = '0;
    illegal = 1'b0;
    case (opc_raw)
      OPC_NOP: ;
      OPC_LW, OPC_ADDI: begin
        ws  = ir[WS_LSB +: REG_SEL_W];
        id  = ir[IMI_LSB +: IMM_W];
        rs1 = ir[0 +: REG_SEL_W];
        re1 = 1'b1;
        ie  = 1'b1;
        we  = 1'b1;
      end
      OPC_SW: begin
        id  = ir[IMS_LSB +: IMM_W];
        rs1 = ir[REG_SEL_W +: REG_SEL_W];
        rs2 = ir[0 +: REG_SEL_W];
        re1 = 1'b1;
        re2 = 1'b1;
        ie  = 1'b1;
      end
      OPC_ADD, OPC_SUB: begin
        ws  = ir[WS_LSB +: REG_SEL_W];
        rs1 = ir[REG_SEL_W +: REG_SEL_W];
        rs2 = ir[0 +: REG_SEL_W];
        re1 = 1'b1;
        re2 = 1'b1;
        we  = 1'b1;
      end
      default: begin
        opcode  = OPC_NOP;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: output register, valid/ready handshake, load-use
// scoreboard with bubble insertion. Optional sticky illegal-opcode trap when
// DECODE_STAGE_ILLEGAL_TRAP_EN is defined.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned REG_SEL_W      = 4,
  parameter int unsigned IMM_W          = 16,
  parameter int unsigned LOAD_USE_STALL = 1
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  decode_stage_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(LOAD_USE_STALL + 1);

  stage_state_e         state_q;
  stage_state_e         state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [REG_SEL_W-1:0] ld_ws_q;
  logic                 trap;

  logic [OPC_W-1:0]     f_opcode;
  logic                 f_re1;
  logic                 f_re2;
  logic [REG_SEL_W-1:0] f_rs1;
  logic [REG_SEL_W-1:0] f_rs2;
  logic                 f_we;
  logic [REG_SEL_W-1:0] f_ws;
  logic                 f_ie;
  logic [IMM_W-1:0]     f_id;
  logic                 f_illegal;

  logic                 out_valid;
  logic                 advance;
  logic                 match_out;
  logic                 match_ld;
  logic                 hazard;
  logic                 ready;
  logic                 accept;
  logic                 xfer;

  decode_fields #(
    .REG_SEL_W (REG_SEL_W),
    .IMM_W     (IMM_W)
  ) u_fields (
    .ir      (bus.i_ir),
    .opcode  (f_opcode),
    .re1     (f_re1),
    .re2     (f_re2),
    .rs1     (f_rs1),
    .rs2     (f_rs2),
    .we      (f_we),
    .ws      (f_ws),
    .ie      (f_ie),
    .id      (f_id),
    .illegal (f_illegal)
  );

  assign out_valid   = (state_q == ST_FULL);
  assign xfer        = out_valid && bus.i_ready;
  assign bus.o_valid = out_valid;
  assign bus.o_ready = ready;

  // Handshake, hazard detection and next-state selection.
  always_comb begin
    advance   = !out_valid || bus.i_ready;
    match_out = (f_re1 && (f_rs1 == bus.o_ws)) || (f_re2 && (f_rs2 == bus.o_ws));
    match_ld  = (f_re1 && (f_rs1 == ld_ws_q)) || (f_re2 && (f_rs2 == ld_ws_q));
    hazard    = bus.i_valid &&
                ((out_valid && (bus.o_opcode == OPC_LW) && match_out) ||
                 ((cnt_q != '0) && match_ld));
    ready     = advance && !hazard && !trap;
    accept    = bus.i_valid && ready;
    state_d   = state_q;
    if (advance) begin
      if (accept) begin
        state_d = ST_FULL;
      end else if (hazard) begin
        state_d = ST_STALL;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  // Stage state register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Decoded-field output register; loads only on accept, holds otherwise.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      bus.o_opcode <= '0;
      bus.o_re1    <= 1'b0;
      bus.o_re2    <= 1'b0;
      bus.o_rs1    <= '0;
      bus.o_rs2    <= '0;
      bus.o_we     <= 1'b0;
      bus.o_ws     <= '0;
      bus.o_ie     <= 1'b0;
      bus.o_id     <= '0;
    end else if (accept) begin
      bus.o_opcode <= f_opcode;
      bus.o_re1    <= f_re1;
      bus.o_re2    <= f_re2;
      bus.o_rs1    <= f_rs1;
      bus.o_rs2    <= f_rs2;
      bus.o_we     <= f_we;
      bus.o_ws     <= f_ws;
      bus.o_ie     <= f_ie;
      bus.o_id     <= f_id;
    end
  end

  // Load scoreboard: remembers the last transferred LW target for the stall window.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_q   <= '0;
      ld_ws_q <= '0;
    end else if (xfer && (bus.o_opcode == OPC_LW)) begin
      cnt_q   <= CNT_W'(LOAD_USE_STALL);
      ld_ws_q <= bus.o_ws;
    end else if (cnt_q != '0) begin
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
  logic trap_q;

  assign trap = trap_q;

  // Illegal flag register and sticky trap set when an illegal instr transfers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      bus.o_illegal <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      if (accept) begin
        bus.o_illegal <= f_illegal;
      end
      if (xfer && bus.o_illegal) begin
        trap_q <= 1'b1;
      end
    end
  end
`else
  logic unused_illegal;

  assign trap           = 1'b0;
  assign bus.o_illegal  = 1'b0;
  assign unused_illegal = f_illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: spec-level model checked every cycle
// plus directed literal expectations.
module tb_decode_stage;
  localparam int unsigned R   = 4;
  localparam int unsigned I   = 16;
  localparam int unsigned LUS = 1;

  typedef struct packed {
    logic [7:0]  opcode;
    logic        re1;
    logic        re2;
    logic        we;
    logic        ie;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  ws;
    logic [15:0] id;
    logic        illegal;
  } fields_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  decode_stage_if #(.REG_SEL_W(R), .IMM_W(I)) bus ();

  decode_stage #(
    .REG_SEL_W      (R),
    .IMM_W          (I),
    .LOAD_USE_STALL (LUS)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode rules expressed directly on the 32-bit instruction word.
  function automatic fields_t model_dec(input logic [31:0] ir);
    fields_t f;
    int unsigned op;
    f  = '0;
    op = 32'(ir >> 24);
    case (op)
      0: ;
      1, 5: begin
        f.opcode = 8'(op); f.ws = 4'(ir >> 20); f.id = 16'(ir >> 4); f.rs1 = 4'(ir);
        f.re1 = 1'b1; f.ie = 1'b1; f.we = 1'b1;
      end
      2: begin
        f.opcode = 8'(op); f.id = 16'(ir >> 8); f.rs1 = 4'(ir >> 4); f.rs2 = 4'(ir);
        f.re1 = 1'b1; f.re2 = 1'b1; f.ie = 1'b1;
      end
      3, 4: begin
        f.opcode = 8'(op); f.ws = 4'(ir >> 20); f.rs1 = 4'(ir >> 4); f.rs2 = 4'(ir);
        f.re1 = 1'b1; f.re2 = 1'b1; f.we = 1'b1;
      end
      default: begin
`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
        f.illegal = 1'b1;
`endif
      end
    endcase
    return f;
  endfunction

  function automatic logic reads(input fields_t f, input logic [3:0] x);
    return (f.re1 && f.rs1 == x) || (f.re2 && f.rs2 == x);
  endfunction

  function automatic fields_t dut_fields();
    fields_t f;
    f.opcode = bus.o_opcode; f.re1 = bus.o_re1; f.re2 = bus.o_re2; f.we = bus.o_we;
    f.ie = bus.o_ie; f.rs1 = bus.o_rs1; f.rs2 = bus.o_rs2; f.ws = bus.o_ws;
    f.id = bus.o_id; f.illegal = bus.o_illegal;
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: output register contents, load scoreboard, trap flag.
  logic    m_valid;
  fields_t m_f;
  int      m_cnt;
  logic [3:0] m_ldws;
  logic    m_trap;

  // Compare process: check DUT against the model each cycle, then step the model.
  initial begin
    logic advance, hz, rdy, xfer;
    fields_t in_f;
    m_valid = 1'b0; m_f = '0; m_cnt = 0; m_ldws = '0; m_trap = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      in_f    = model_dec(bus.i_ir);
      advance = !m_valid || bus.i_ready;
      hz      = bus.i_valid && ((m_valid && m_f.opcode == 8'd1 && reads(in_f, m_f.ws)) ||
                                (m_cnt != 0 && reads(in_f, m_ldws)));
      rdy     = advance && !hz && !m_trap;
      chk("o_valid", 32'(bus.o_valid), 32'(m_valid));
      chk("o_ready", 32'(bus.o_ready), 32'(rdy));
      if (m_valid) begin
        n_chk++;
        if (dut_fields() !== m_f) begin
          n_fail++;
          $display("FAIL fields: got 0x%0h expected 0x%0h at %0t", dut_fields(), m_f, $time);
        end
      end
      if (!rst_n) begin
        m_valid = 1'b0; m_f = '0; m_cnt = 0; m_ldws = '0; m_trap = 1'b0;
      end else begin
        xfer = m_valid && bus.i_ready;
        if (xfer && m_f.illegal) m_trap = 1'b1;
        if (xfer && m_f.opcode == 8'd1) begin
          m_cnt = LUS; m_ldws = m_f.ws;
        end else if (m_cnt > 0) begin
          m_cnt--;
        end
        if (advance) begin
          m_valid = bus.i_valid && rdy;
          if (m_valid) m_f = in_f;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Present ir until accepted; waits returns the number of refused cycles.
  task automatic send(input logic [31:0] ir, output int waits);
    waits = 0;
    bus.i_valid = 1'b1;
    bus.i_ir    = ir;
    forever begin
      @(negedge clk);
      if (bus.o_ready) break;
      waits++;
      if (waits > 50) begin
        n_chk++; n_fail++;
        $display("FAIL send_timeout: ir 0x%0h never accepted", ir);
        break;
      end
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  initial begin
    int w;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_ir = '0; bus.i_ready = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_o_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_fields", 32'({bus.o_opcode, bus.o_ws, bus.o_id}), 32'd0);
    chk("rst_illegal", 32'(bus.o_illegal), 32'd0);
    @(posedge clk); #1;

    // LW r2,0x0010(r1)
    send(32'h01200101, w);
    chk("lw_valid", 32'(bus.o_valid), 32'd1);
    chk("lw_ws", 32'(bus.o_ws), 32'd2);
    chk("lw_id", 32'(bus.o_id), 32'h0010);
    chk("lw_rs1", 32'(bus.o_rs1), 32'd1);
    chk("lw_en", 32'({bus.o_we, bus.o_ie, bus.o_re1, bus.o_re2}), 32'b1110);
    cyc(3);

    // Dependent ADD: refused while LW sits at the output, then for the scoreboard window.
    send(32'h01200101, w);
    send(32'h03300024, w);
    chk("dep_add_stall", 32'(w), 32'(LUS + 1));
    chk("dep_add_ws", 32'(bus.o_ws), 32'd3);
    cyc(3);

    // Independent ADD right after LW: no bubble.
    send(32'h01200101, w);
    send(32'h03300054, w);
    chk("indep_add_stall", 32'(w), 32'd0);
    chk("indep_add_rs", 32'({bus.o_rs1, bus.o_rs2}), 32'h54);
    cyc(3);

    // Backpressure: SUB held at the output for 3 cycles, ADDI waits upstream.
    send(32'h04500021, w);
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_ir    = 32'h057FFFF1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_ready", 32'(bus.o_ready), 32'd0);
      chk("hold_sub", 32'({bus.o_opcode, bus.o_ws, bus.o_rs1, bus.o_rs2}), 32'h04_5_2_1);
    end
    @(posedge clk); #1;
    bus.i_ready = 1'b1;
    send(32'h057FFFF1, w);
    chk("addi_ws", 32'(bus.o_ws), 32'd7);
    chk("addi_id", 32'(bus.o_id), 32'hFFFF);
    chk("addi_en", 32'({bus.o_we, bus.o_ie, bus.o_re1, bus.o_re2}), 32'b1110);

    // SW
    send(32'h02ABCD12, w);
    chk("sw_id", 32'(bus.o_id), 32'hABCD);
    chk("sw_rs", 32'({bus.o_rs1, bus.o_rs2}), 32'h12);
    chk("sw_en", 32'({bus.o_we, bus.o_ie, bus.o_re1, bus.o_re2}), 32'b0111);
    cyc(2);

    // Illegal opcode 0x09.
    send(32'h09123456, w);
    chk("ill_opcode", 32'(bus.o_opcode), 32'd0);
    chk("ill_we", 32'(bus.o_we), 32'd0);
`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
    chk("ill_flag", 32'(bus.o_illegal), 32'd1);
    cyc(1);
    bus.i_valid = 1'b1;
    bus.i_ir    = 32'h03300054;
    repeat (3) begin
      @(negedge clk);
      chk("trap_ready", 32'(bus.o_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
`else
    chk("ill_flag", 32'(bus.o_illegal), 32'd0);
    send(32'h03300054, w);
    chk("after_ill_stall", 32'(w), 32'd0);
`endif
    cyc(3);

    // Reset during a load-use stall drops the held ADD and clears the scoreboard.
    send(32'h01200101, w);
    bus.i_valid = 1'b1;
    bus.i_ir    = 32'h03300024;
    @(negedge clk);
    chk("stall_ready", 32'(bus.o_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.o_valid), 32'd0);
    chk("post_rst_ready", 32'(bus.o_ready), 32'd1);
    @(posedge clk); #1;
    send(32'h03300024, w);
    chk("post_rst_add_stall", 32'(w), 32'd0);
    chk("post_rst_add_valid", 32'(bus.o_valid), 32'd1);
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
